// File: rtl/wb_arbiter.sv
// Writeback arbiter: two small result FIFOs (RS, LSB) share one registered ROB submit port
// through a round-robin grant. A mispredict flush drops every queued and in-flight result.
module wb_arbiter #(
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              predict_fail,
  input  logic              in_valid_rs,
  input  logic [TAG_W-1:0]  in_tag_rs,
  input  logic [DATA_W-1:0] in_val_rs,
  output logic              in_ready_rs,
  input  logic              in_valid_lsb,
  input  logic [TAG_W-1:0]  in_tag_lsb,
  input  logic [DATA_W-1:0] in_val_lsb,
  output logic              in_ready_lsb,
  output logic              out_valid,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_val
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned EntW = TAG_W + DATA_W;
  localparam logic [CntW-1:0] CntFull = CntW'(QUEUE_DEPTH);

  // Source index 0 is RS, 1 is LSB.
  logic [1:0]             src_valid;
  logic [1:0][TAG_W-1:0]  src_tag;
  logic [1:0][DATA_W-1:0] src_val;
  logic [1:0]             ready;
  logic [1:0]             push;
  logic [1:0]             pop;
  logic [1:0]             nonempty;
  logic                   accept_en;

  logic [EntW-1:0]        mem_q [2][QUEUE_DEPTH];
  logic [1:0][PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0][PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0][CntW-1:0]   count_q, count_d;
  logic                   rr_pri_q, rr_pri_d;
  logic                   out_valid_q, out_valid_d;
  logic [TAG_W-1:0]       out_tag_q, out_tag_d;
  logic [DATA_W-1:0]      out_val_q, out_val_d;

  logic                   gnt_vld;
  logic                   gnt_src;
  logic [EntW-1:0]        head;

  assign src_valid = {in_valid_lsb, in_valid_rs};
  assign src_tag   = {in_tag_lsb, in_tag_rs};
  assign src_val   = {in_val_lsb, in_val_rs};
  assign accept_en = !rst_in && rdy_in && !predict_fail;

  always_comb begin
    ready    = '0;
    push     = '0;
    nonempty = '0;
    for (int s = 0; s < 2; s++) begin
      ready[s]    = accept_en && (count_q[s] != CntFull);
      // Tag 0 completes the handshake but is never queued.
      push[s]     = src_valid[s] && ready[s] && (src_tag[s] != '0);
      nonempty[s] = (count_q[s] != '0);
    end
  end

  assign in_ready_rs  = ready[0];
  assign in_ready_lsb = ready[1];

  always_comb begin
    gnt_vld  = |nonempty;
    gnt_src  = (&nonempty) ? rr_pri_q : nonempty[1];
    head     = mem_q[gnt_src][rd_ptr_q[gnt_src]];
    pop      = '0;
    rr_pri_d = rr_pri_q;
    if (gnt_vld) begin
      pop[gnt_src] = 1'b1;
      rr_pri_d     = ~gnt_src;
    end
    out_valid_d = gnt_vld;
    out_tag_d   = '0;
    out_val_d   = '0;
    if (gnt_vld) begin
      {out_tag_d, out_val_d} = head;
    end
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int s = 0; s < 2; s++) begin
      rd_ptr_d[s] = rd_ptr_q[s] + PtrW'(pop[s]);
      wr_ptr_d[s] = wr_ptr_q[s] + PtrW'(push[s]);
      count_d[s]  = count_q[s] + CntW'(push[s]) - CntW'(pop[s]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || (rdy_in && predict_fail)) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      rr_pri_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_val_q   <= '0;
    end else if (rdy_in) begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      rr_pri_q    <= rr_pri_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_val_q   <= out_val_d;
    end
  end

  // Payload storage needs no reset; validity lives in the counts.
  always_ff @(posedge clk_in) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        mem_q[s][wr_ptr_q[s]] <= {src_tag[s], src_val[s]};
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_val   = out_val_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: cycle table for single-source, contention, freeze and flush,
// plus hand sequences for tag-zero drop and a saturated backpressure scoreboard.
module tb_wb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, predict_fail;
  logic        in_valid_rs, in_valid_lsb;
  logic [3:0]  in_tag_rs, in_tag_lsb;
  logic [31:0] in_val_rs, in_val_lsb;
  logic        in_ready_rs, in_ready_lsb;
  logic        out_valid;
  logic [3:0]  out_tag;
  logic [31:0] out_val;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  wb_arbiter #(
    .QUEUE_DEPTH(2),
    .TAG_W      (4),
    .DATA_W     (32)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .predict_fail(predict_fail),
    .in_valid_rs (in_valid_rs),
    .in_tag_rs   (in_tag_rs),
    .in_val_rs   (in_val_rs),
    .in_ready_rs (in_ready_rs),
    .in_valid_lsb(in_valid_lsb),
    .in_tag_lsb  (in_tag_lsb),
    .in_val_lsb  (in_val_lsb),
    .in_ready_lsb(in_ready_lsb),
    .out_valid   (out_valid),
    .out_tag     (out_tag),
    .out_val     (out_val)
  );

  typedef struct {
    logic        rst, rdy, pf;
    logic        vr;
    logic [3:0]  tr;
    logic [31:0] dr;
    logic        vl;
    logic [3:0]  tl;
    logic [31:0] dl;
    logic        er, el;
    logic        eov;
    logic [3:0]  etag;
    logic [31:0] eval;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic rst, input logic rdy, input logic pf,
                              input logic vr, input logic [3:0] tr, input logic [31:0] dr,
                              input logic vl, input logic [3:0] tl, input logic [31:0] dl,
                              input logic er, input logic el,
                              input logic eov, input logic [3:0] etag, input logic [31:0] eval);
    vec_t v;
    v = '{rst, rdy, pf, vr, tr, dr, vl, tl, dl, er, el, eov, etag, eval};
    vt.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic pf,
                       input logic vr, input logic [3:0] tr, input logic [31:0] dr,
                       input logic vl, input logic [3:0] tl, input logic [31:0] dl);
    rst_in = rst; rdy_in = rdy; predict_fail = pf;
    in_valid_rs = vr; in_tag_rs = tr; in_val_rs = dr;
    in_valid_lsb = vl; in_tag_lsb = tl; in_val_lsb = dl;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_out(input string name, input logic ov, input logic [3:0] tg,
                         input logic [31:0] vl);
    chk({name, " out_valid"}, 64'(out_valid), 64'(ov));
    chk({name, " out_tag"}, 64'(out_tag), 64'(tg));
    chk({name, " out_val"}, 64'(out_val), 64'(vl));
  endtask

  initial begin
    int rs_i, l_i, rs_exp, l_exp;
    bit saw_block, acc_rs, acc_l;

    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);

    // rst rdy pf | RS v,tag,val | LSB v,tag,val | ready rs,lsb | out v,tag,val (after edge)
    add(1,1,0, 0,0,0,      0,0,0,       0,0, 0,0,0);
    // single source: RS tag 3 appears two edges later, for one cycle
    add(0,1,0, 1,3,'h11,   0,0,0,       1,1, 0,0,0);
    add(0,1,0, 0,0,0,      0,0,0,       1,1, 1,3,'h11);
    add(0,1,0, 0,0,0,      0,0,0,       1,1, 0,0,0);
    add(1,1,0, 0,0,0,      0,0,0,       0,0, 0,0,0);
    // contention: sources re-present a refused result
    add(0,1,0, 1,1,'h101,  1,9,'h209,   1,1, 0,0,0);
    add(0,1,0, 1,2,'h102,  1,10,'h20a,  1,1, 1,1,'h101);
    add(0,1,0, 1,3,'h103,  1,11,'h20b,  1,0, 1,9,'h209);
    add(0,1,0, 1,4,'h104,  1,11,'h20b,  0,1, 1,2,'h102);
    add(0,1,0, 1,4,'h104,  1,12,'h20c,  1,0, 1,10,'h20a);
    add(0,1,0, 1,5,'h105,  1,12,'h20c,  0,1, 1,3,'h103);
    add(0,1,0, 1,5,'h105,  1,13,'h20d,  1,0, 1,11,'h20b);
    add(0,1,0, 0,0,0,      0,0,0,       0,1, 1,4,'h104);
    add(0,1,0, 0,0,0,      0,0,0,       1,1, 1,12,'h20c);
    add(0,1,0, 0,0,0,      0,0,0,       1,1, 1,5,'h105);
    add(0,1,0, 0,0,0,      0,0,0,       1,1, 0,0,0);
    // freeze with tag 5 on the output
    add(0,1,0, 1,5,'h55,   0,0,0,       1,1, 0,0,0);
    add(0,1,0, 1,6,'h66,   0,0,0,       1,1, 1,5,'h55);
    add(0,0,0, 0,0,0,      0,0,0,       0,0, 1,5,'h55);
    add(0,0,0, 1,7,'h77,   0,0,0,       0,0, 1,5,'h55);
    add(0,0,0, 0,0,0,      0,0,0,       0,0, 1,5,'h55);
    add(0,1,0, 0,0,0,      0,0,0,       1,1, 1,6,'h66);
    add(0,1,0, 0,0,0,      0,0,0,       1,1, 0,0,0);
    // flush with both FIFOs loaded; rr_pri is 1 here so LSB wins first
    add(0,1,0, 1,1,'h101,  1,9,'h209,   1,1, 0,0,0);
    add(0,1,0, 1,2,'h102,  1,10,'h20a,  1,1, 1,9,'h209);
    add(0,1,0, 1,3,'h103,  1,11,'h20b,  0,1, 1,1,'h101);
    add(0,1,0, 1,3,'h103,  1,12,'h20c,  1,0, 1,10,'h20a);
    add(0,1,1, 1,4,'h104,  1,12,'h20c,  0,0, 0,0,0);
    add(0,1,0, 0,0,0,      0,0,0,       1,1, 0,0,0);
    add(0,1,0, 0,0,0,      0,0,0,       1,1, 0,0,0);
    add(0,1,0, 0,0,0,      0,0,0,       1,1, 0,0,0);
    add(0,1,0, 0,0,0,      0,0,0,       1,1, 0,0,0);
    // after flush rr_pri is back to RS
    add(0,1,0, 1,7,'h107,  1,8,'h208,   1,1, 0,0,0);
    add(0,1,0, 0,0,0,      0,0,0,       1,1, 1,7,'h107);
    add(0,1,0, 0,0,0,      0,0,0,       1,1, 1,8,'h208);
    add(0,1,0, 0,0,0,      0,0,0,       1,1, 0,0,0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst, vt[i].rdy, vt[i].pf, vt[i].vr, vt[i].tr, vt[i].dr,
            vt[i].vl, vt[i].tl, vt[i].dl);
      #1;
      chk($sformatf("v%0d in_ready_rs", i), 64'(in_ready_rs), 64'(vt[i].er));
      chk($sformatf("v%0d in_ready_lsb", i), 64'(in_ready_lsb), 64'(vt[i].el));
      tick();
      chk_out($sformatf("v%0d", i), vt[i].eov, vt[i].etag, vt[i].eval);
    end

    // Tag zero: accepted but never queued, so tag 7 is the first thing out.
    drive(0, 1, 0, 0, 0, 0, 1, 0, 'hFF);
    #1;
    chk("tag0 ready", 64'(in_ready_lsb), 64'(1));
    tick();
    chk_out("tag0 e1", 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 0, 'hFF);
    tick();
    chk_out("tag0 e2", 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 7, 'h77);
    tick();
    chk_out("tag0 e3", 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_out("tag0 t7", 1, 7, 'h77);
    tick();
    chk_out("tag0 e4", 0, 0, 0);

    // Backpressure: both sources saturated, RS must be refused at least once.
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rs_i = 0; l_i = 0; rs_exp = 0; l_exp = 0; saw_block = 0;
    for (int c = 0; c < 40; c++) begin
      drive(0, 1, 0, rs_i < 4, 4'(1 + rs_i), 32'h300 + 32'(1 + rs_i),
            l_i < 6, 4'(9 + l_i), 32'h400 + 32'(9 + l_i));
      #1;
      acc_rs = in_valid_rs && in_ready_rs;
      acc_l  = in_valid_lsb && in_ready_lsb;
      if (in_valid_rs && !in_ready_rs) saw_block = 1;
      tick();
      if (acc_rs) rs_i++;
      if (acc_l) l_i++;
      if (out_valid) begin
        if (out_tag < 9) begin
          chk("bp rs tag", 64'(out_tag), 64'(1 + rs_exp));
          chk("bp rs val", 64'(out_val), 64'(32'h300 + 32'(1 + rs_exp)));
          rs_exp++;
        end else begin
          chk("bp lsb tag", 64'(out_tag), 64'(9 + l_exp));
          chk("bp lsb val", 64'(out_val), 64'(32'h400 + 32'(9 + l_exp)));
          l_exp++;
        end
      end
    end
    chk("bp rs count", 64'(rs_exp), 64'(4));
    chk("bp lsb count", 64'(l_exp), 64'(6));
    chk("bp rs refused", 64'(saw_block), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
